// File: rtl/mcp_pkg.sv
// Shared types and helpers for the multi-cycle core: opcode/state encodings,
// instruction field slicing for any register-address width, and sign extension.
package mcp_pkg;

    localparam int MAX_RA          = 8;
    localparam int MAX_INSTR_WIDTH = 2 + 3 * MAX_RA;
    localparam int MAX_WIDTH       = 64;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_JMP = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5
    } state_e;

    // Field at position pos (0 = rd/imm, 1 = rt, 2 = rs) for an RA-bit register address.
    function automatic logic [MAX_RA-1:0] field_at(input logic [MAX_INSTR_WIDTH-1:0] instr,
                                                  input int ra, input int pos);
        logic [MAX_INSTR_WIDTH-1:0] shifted;
        logic [MAX_RA-1:0]          mask;
        shifted = instr >> (pos * ra);
        mask    = {MAX_RA{1'b1}} >> (MAX_RA - ra);
        return shifted[MAX_RA-1:0] & mask;
    endfunction

    function automatic opcode_e instr_op(input logic [MAX_INSTR_WIDTH-1:0] instr, input int ra);
        logic [MAX_INSTR_WIDTH-1:0] shifted;
        shifted = instr >> (3 * ra);
        return opcode_e'(shifted[1:0]);
    endfunction

    function automatic logic [MAX_RA-1:0] instr_rs(input logic [MAX_INSTR_WIDTH-1:0] instr, input int ra);
        return field_at(instr, ra, 2);
    endfunction

    function automatic logic [MAX_RA-1:0] instr_rt(input logic [MAX_INSTR_WIDTH-1:0] instr, input int ra);
        return field_at(instr, ra, 1);
    endfunction

    function automatic logic [MAX_RA-1:0] instr_imm(input logic [MAX_INSTR_WIDTH-1:0] instr, input int ra);
        return field_at(instr, ra, 0);
    endfunction

    // Sign-extend the low ra bits of imm to MAX_WIDTH; callers truncate to their width.
    function automatic logic [MAX_WIDTH-1:0] sext(input logic [MAX_RA-1:0] imm, input int ra);
        logic [MAX_WIDTH-1:0] shifted;
        shifted = {{(MAX_WIDTH - MAX_RA){1'b0}}, imm} << (MAX_WIDTH - ra);
        return $signed(shifted) >>> (MAX_WIDTH - ra);
    endfunction

endpackage

// File: rtl/mcp_register_file.sv
// General-purpose register file: two combinational read ports and one
// synchronous write port, cleared by the synchronous active-low clear.
module mcp_register_file #(
    parameter  int DATA_WIDTH = 8,
    parameter  int REG_COUNT  = 4,
    localparam int RA         = $clog2(REG_COUNT)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  we,
    input  logic [RA-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [RA-1:0]         raddr_a,
    input  logic [RA-1:0]         raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];

    // Register storage with synchronous clear and single write port.
    always_ff @(posedge clock) begin
        if (!clear) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_r[raddr_a];
    assign rdata_b = regs_r[raddr_b];

endmodule

// File: rtl/multicycle_processor.sv
// Multi-cycle four-opcode core: FSM, ALU and datapath registers, with
// instruction and data memories reached through req/ack handshakes.
module multicycle_processor
    import mcp_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int REG_COUNT   = 4,
    parameter  int PC_WIDTH    = 8,
    localparam int RA          = $clog2(REG_COUNT),
    localparam int INSTR_WIDTH = 2 + 3 * RA
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   enable,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [DATA_WIDTH-1:0]  dmem_addr,
    output logic [DATA_WIDTH-1:0]  dmem_wdata,
    input  logic                   dmem_ack,
    input  logic [DATA_WIDTH-1:0]  dmem_rdata,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   result_valid
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH - 1){1'b0}}, 1'b1};

    state_e                     state_r, state_next_s;
    logic [PC_WIDTH-1:0]        pc_r;
    logic [INSTR_WIDTH-1:0]     ir_r;
    logic [DATA_WIDTH-1:0]      a_r, b_r, imm_r, alu_out_r, mdr_r, result_r;
    logic                       result_valid_r, imem_req_r, dmem_req_r, dmem_we_r;

    logic [MAX_INSTR_WIDTH-1:0] ir_ext_s;
    opcode_e                    op_s;
    logic [RA-1:0]              rs_s, rt_s, rd_s;
    logic [DATA_WIDTH-1:0]      imm_data_s;
    logic [PC_WIDTH-1:0]        imm_pc_s;
    logic [DATA_WIDTH-1:0]      rdata_a_s, rdata_b_s;
    logic                       rf_we_s;
    logic [RA-1:0]              rf_waddr_s;
    logic [DATA_WIDTH-1:0]      rf_wdata_s;

    assign ir_ext_s   = MAX_INSTR_WIDTH'(ir_r);
    assign op_s       = instr_op(ir_ext_s, RA);
    assign rs_s       = RA'(instr_rs(ir_ext_s, RA));
    assign rt_s       = RA'(instr_rt(ir_ext_s, RA));
    assign rd_s       = RA'(instr_imm(ir_ext_s, RA));
    assign imm_data_s = DATA_WIDTH'(sext(MAX_RA'(rd_s), RA));
    assign imm_pc_s   = PC_WIDTH'(sext(MAX_RA'(rd_s), RA));

    mcp_register_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_register_file (
        .clock   (clock),
        .clear   (clear),
        .we      (rf_we_s),
        .waddr   (rf_waddr_s),
        .wdata   (rf_wdata_s),
        .raddr_a (rs_s),
        .raddr_b (rt_s),
        .rdata_a (rdata_a_s),
        .rdata_b (rdata_b_s)
    );

    // Write-back port: ADD writes ALUOUT to rd, LW writes MDR to rt.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = rt_s;
        rf_wdata_s = mdr_r;
        if ((state_r == WRITEBACK) && enable) begin
            rf_we_s = 1'b1;
        end else begin
            rf_we_s = 1'b0;
        end
        if (op_s == OP_ADD) begin
            rf_waddr_s = rd_s;
            rf_wdata_s = alu_out_r;
        end else begin
            rf_waddr_s = rt_s;
            rf_wdata_s = mdr_r;
        end
    end

    // Next-state logic: handshake states follow ack, the rest step on enable.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) state_next_s = FETCH;
                else        state_next_s = IDLE;
            end
            FETCH: begin
                if (imem_ack && imem_req_r) state_next_s = DECODE;
                else                        state_next_s = FETCH;
            end
            DECODE: begin
                if (enable) state_next_s = EXECUTE;
                else        state_next_s = DECODE;
            end
            EXECUTE: begin
                if (enable) begin
                    case (op_s)
                        OP_ADD:  state_next_s = WRITEBACK;
                        OP_LW:   state_next_s = MEM;
                        OP_SW:   state_next_s = MEM;
                        OP_JMP:  state_next_s = FETCH;
                        default: state_next_s = IDLE;
                    endcase
                end else begin
                    state_next_s = EXECUTE;
                end
            end
            MEM: begin
                if (dmem_ack && dmem_req_r) begin
                    if (op_s == OP_LW) state_next_s = WRITEBACK;
                    else               state_next_s = FETCH;
                end else begin
                    state_next_s = MEM;
                end
            end
            WRITEBACK: begin
                if (enable) state_next_s = FETCH;
                else        state_next_s = WRITEBACK;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_r        <= IDLE;
            pc_r           <= {PC_WIDTH{1'b0}};
            ir_r           <= {INSTR_WIDTH{1'b0}};
            a_r            <= {DATA_WIDTH{1'b0}};
            b_r            <= {DATA_WIDTH{1'b0}};
            imm_r          <= {DATA_WIDTH{1'b0}};
            alu_out_r      <= {DATA_WIDTH{1'b0}};
            mdr_r          <= {DATA_WIDTH{1'b0}};
            result_r       <= {DATA_WIDTH{1'b0}};
            result_valid_r <= 1'b0;
            imem_req_r     <= 1'b0;
            dmem_req_r     <= 1'b0;
            dmem_we_r      <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            // Requests track the state being entered so they are clean flop outputs.
            imem_req_r     <= (state_next_s == FETCH);
            dmem_req_r     <= (state_next_s == MEM);
            dmem_we_r      <= (state_next_s == MEM) && (op_s == OP_SW);
            result_valid_r <= 1'b0;
            case (state_r)
                FETCH: begin
                    if (imem_ack && imem_req_r) begin
                        ir_r <= imem_data;
                        pc_r <= pc_r + PC_ONE;
                    end
                end
                DECODE: begin
                    if (enable) begin
                        a_r   <= rdata_a_s;
                        b_r   <= rdata_b_s;
                        imm_r <= imm_data_s;
                    end
                end
                EXECUTE: begin
                    if (enable) begin
                        case (op_s)
                            OP_ADD:  alu_out_r <= a_r + b_r;
                            OP_LW:   alu_out_r <= a_r + imm_r;
                            OP_SW:   alu_out_r <= a_r + imm_r;
                            // pc already holds the fetch address plus one.
                            OP_JMP:  pc_r <= pc_r + imm_pc_s;
                            default: alu_out_r <= alu_out_r;
                        endcase
                    end
                end
                MEM: begin
                    if (dmem_ack && dmem_req_r && (op_s == OP_LW)) begin
                        mdr_r <= dmem_rdata;
                    end
                end
                WRITEBACK: begin
                    if (enable) begin
                        result_r       <= rf_wdata_s;
                        result_valid_r <= 1'b1;
                    end
                end
                default: begin
                    result_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = imem_req_r;
    assign imem_addr    = pc_r;
    assign dmem_req     = dmem_req_r;
    assign dmem_we      = dmem_we_r;
    assign dmem_addr    = alu_out_r;
    assign dmem_wdata   = b_r;
    assign pc           = pc_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;

endmodule

// File: tb/tb_multicycle_processor.sv
// Directed bench for multicycle_processor: a table of single instructions run
// back to back from address 0, then hand-written stall, freeze, reset and wrap sequences.
module tb_multicycle_processor;

    logic       clock = 1'b0;
    logic       clear;
    logic       enable;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack   = 1'b0;
    logic [7:0] imem_data  = 8'h00;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic       dmem_ack   = 1'b0;
    logic [7:0] dmem_rdata = 8'h00;
    logic [7:0] pc;
    logic [7:0] result;
    logic       result_valid;

    logic [7:0] imem_mem [256];
    logic [7:0] dmem_mem [256];
    logic [1:0] imem_mode;  // 0: ack follows req, 1: forced high, 2: held low
    logic [1:0] dmem_mode;

    int         acc_count   = 0;
    logic [7:0] last_daddr  = 8'h00;
    logic       last_dwe    = 1'b0;
    logic [7:0] last_dwdata = 8'h00;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] instr;
        int         cycles;
        int         exp_valid;
        logic [7:0] exp_result;
        logic [7:0] exp_pc;
        int         exp_acc;
        logic [7:0] exp_daddr;
        logic       exp_dwe;
        logic [7:0] exp_dwdata;
    } vec_t;

    vec_t vecs [6];

    multicycle_processor dut (
        .clock        (clock),
        .clear        (clear),
        .enable       (enable),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .pc           (pc),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clock = ~clock;

    // Zero-wait memory models, responding half a cycle ahead of the accepting edge.
    always @(negedge clock) begin
        case (imem_mode)
            2'd1:    imem_ack = 1'b1;
            2'd2:    imem_ack = 1'b0;
            default: imem_ack = imem_req;
        endcase
        imem_data = imem_mem[imem_addr];
        case (dmem_mode)
            2'd1:    dmem_ack = 1'b1;
            2'd2:    dmem_ack = 1'b0;
            default: dmem_ack = dmem_req;
        endcase
        dmem_rdata = dmem_mem[dmem_addr];
        if (dmem_req && dmem_ack) begin
            acc_count   = acc_count + 1;
            last_daddr  = dmem_addr;
            last_dwe    = dmem_we;
            last_dwdata = dmem_wdata;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int valid_seen;
        int acc_before;

        for (int i = 0; i < 256; i++) begin
            imem_mem[i] = 8'h00;
            dmem_mem[i] = 8'h00;
        end
        dmem_mem[8'h01] = 8'h2A;
        dmem_mem[8'hFE] = 8'h80;

        //          instr  cyc val result pc    acc addr   we    wdata
        vecs[0] = '{8'h45, 5,  1,  8'h2A, 8'h01, 1, 8'h01, 1'b0, 8'h00};  // LW  r1 <- mem[0x01]
        vecs[1] = '{8'h16, 4,  1,  8'h54, 8'h02, 0, 8'h00, 1'b0, 8'h00};  // ADD r2 <- r1 + r1
        vecs[2] = '{8'h87, 4,  0,  8'h54, 8'h03, 1, 8'hFF, 1'b1, 8'h2A};  // SW  mem[0xFF] <- r1
        vecs[3] = '{8'h46, 5,  1,  8'h80, 8'h04, 1, 8'hFE, 1'b0, 8'h00};  // LW  r1 <- mem[0xFE]
        vecs[4] = '{8'h16, 4,  1,  8'h00, 8'h05, 0, 8'h00, 1'b0, 8'h00};  // ADD 0x80+0x80 wraps
        vecs[5] = '{8'hC2, 3,  0,  8'h00, 8'h04, 0, 8'h00, 1'b0, 8'h00};  // JMP -2 from 0x05
        for (int i = 0; i < 6; i++) imem_mem[i] = vecs[i].instr;

        // Reset held for three edges with both acks forced high.
        clear     = 1'b0;
        enable    = 1'b1;
        imem_mode = 2'd1;
        dmem_mode = 2'd1;
        for (int i = 0; i < 3; i++) step();
        check("rst_pc",           32'(pc),           32'h00);
        check("rst_imem_addr",    32'(imem_addr),    32'h00);
        check("rst_imem_req",     32'(imem_req),     32'h0);
        check("rst_dmem_req",     32'(dmem_req),     32'h0);
        check("rst_dmem_we",      32'(dmem_we),      32'h0);
        check("rst_dmem_addr",    32'(dmem_addr),    32'h00);
        check("rst_dmem_wdata",   32'(dmem_wdata),   32'h00);
        check("rst_result",       32'(result),       32'h00);
        check("rst_result_valid", 32'(result_valid), 32'h0);

        clear     = 1'b1;
        imem_mode = 2'd0;
        dmem_mode = 2'd0;
        check("idle_imem_req", 32'(imem_req), 32'h0);
        step();
        check("fetch_imem_req", 32'(imem_req), 32'h1);

        for (int i = 0; i < 6; i++) begin
            valid_seen = 0;
            acc_before = acc_count;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step();
                if (result_valid === 1'b1) valid_seen = valid_seen + 1;
            end
            check($sformatf("v%0d_valid_pulses", i), 32'(valid_seen),          32'(vecs[i].exp_valid));
            check($sformatf("v%0d_result", i),       32'(result),              32'(vecs[i].exp_result));
            check($sformatf("v%0d_pc", i),           32'(pc),                  32'(vecs[i].exp_pc));
            check($sformatf("v%0d_imem_addr", i),    32'(imem_addr),           32'(vecs[i].exp_pc));
            check($sformatf("v%0d_back_in_fetch", i), 32'(imem_req),           32'h1);
            check($sformatf("v%0d_dmem_idle", i),    32'(dmem_req),            32'h0);
            check($sformatf("v%0d_accesses", i),     32'(acc_count - acc_before), 32'(vecs[i].exp_acc));
            if (vecs[i].exp_acc != 0) begin
                check($sformatf("v%0d_dmem_addr", i), 32'(last_daddr), 32'(vecs[i].exp_daddr));
                check($sformatf("v%0d_dmem_we", i),   32'(last_dwe),   32'(vecs[i].exp_dwe));
                if (vecs[i].exp_dwe) begin
                    check($sformatf("v%0d_dmem_wdata", i), 32'(last_dwdata), 32'(vecs[i].exp_dwdata));
                end
            end
        end

        // Fetch stall at pc 0x04: request and address must hold.
        imem_mem[4] = 8'h1B;  // ADD r3 <- r1 + r2 = 0x80 + 0x00
        imem_mode   = 2'd2;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("stall%0d_imem_req", c),  32'(imem_req),  32'h1);
            check($sformatf("stall%0d_imem_addr", c), 32'(imem_addr), 32'h04);
        end
        imem_mode = 2'd0;
        step();
        check("decode_pc",       32'(pc),       32'h05);
        check("decode_imem_req", 32'(imem_req), 32'h0);

        // Freeze in DECODE, then the ADD must still need exactly three more steps.
        enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("freeze%0d_valid", c),    32'(result_valid), 32'h0);
            check($sformatf("freeze%0d_imem_req", c), 32'(imem_req),     32'h0);
            check($sformatf("freeze%0d_dmem_req", c), 32'(dmem_req),     32'h0);
            check($sformatf("freeze%0d_pc", c),       32'(pc),           32'h05);
        end
        enable     = 1'b1;
        valid_seen = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (result_valid === 1'b1) valid_seen = valid_seen + 1;
        end
        check("thaw_valid_pulses", 32'(valid_seen), 32'h1);
        check("thaw_result",       32'(result),     32'h80);
        check("thaw_imem_req",     32'(imem_req),   32'h1);

        // LW stuck in MEM, then reset mid-handshake.
        imem_mem[5] = 8'h45;
        dmem_mode   = 2'd2;
        for (int c = 0; c < 3; c++) step();
        check("memwait_dmem_req",  32'(dmem_req),  32'h1);
        check("memwait_dmem_addr", 32'(dmem_addr), 32'h01);
        check("memwait_dmem_we",   32'(dmem_we),   32'h0);
        for (int c = 0; c < 2; c++) step();
        check("memwait_held_req", 32'(dmem_req), 32'h1);
        clear = 1'b0;
        step();
        check("midrst_dmem_req", 32'(dmem_req),     32'h0);
        check("midrst_pc",       32'(pc),           32'h00);
        check("midrst_imem_req", 32'(imem_req),     32'h0);
        check("midrst_result",   32'(result),       32'h00);
        check("midrst_valid",    32'(result_valid), 32'h0);

        // JMP -2 from 0x00 lands on 0xFF; JMP 0 from 0xFF wraps to 0x00.
        imem_mem[0]   = 8'hC2;
        imem_mem[255] = 8'hC0;
        dmem_mode     = 2'd0;
        clear         = 1'b1;
        step();
        check("wrap_start_addr", 32'(imem_addr), 32'h00);
        for (int c = 0; c < 3; c++) step();
        check("jmp_back_addr", 32'(imem_addr), 32'hFF);
        check("jmp_back_req",  32'(imem_req),  32'h1);
        for (int c = 0; c < 3; c++) step();
        check("jmp_wrap_addr", 32'(imem_addr), 32'h00);
        check("jmp_wrap_pc",   32'(pc),        32'h00);
        check("jmp_wrap_req",  32'(imem_req),  32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
